regfile_access_sequencer: RTL
=============================

Name: regfile_access_sequencer

Overview:
- Initiator side of the 4x8 accumulator register file: takes one operand-fetch/writeback request at a time and drives the register file's read-address, write-address, write-data and write-enable pins.
- Samples operands and hands them to the ALU, waits for the ALU result, performs a single-cycle writeback and captures the CZN flags the register file reports for that write.
- Sits between the multicycle controller and register_file.

Parameters:
- WORD_LENGTH, 8: data width of operands, result and write data.
- READ_WAIT, 1: cycles between presenting read addresses and sampling read data; 0 is treated as 1.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  controller request strobe
- req_ready  out  1  high only in IDLE
- req_rs1  in  2  first source register index
- req_rs2  in  2  second source register index
- req_rd  in  2  destination register index
- req_wb  in  1  1 = write result back to req_rd
- rf_read_reg1  out  2  to register file read_reg1
- rf_read_reg2  out  2  to register file read_reg2
- rf_read_data1  in  WORD_LENGTH  from register file
- rf_read_data2  in  WORD_LENGTH  from register file
- op_a  out  WORD_LENGTH  captured operand 1
- op_b  out  WORD_LENGTH  captured operand 2
- op_valid  out  1  operands valid, ALU may compute
- res_valid  in  1  ALU result strobe
- res_data  in  WORD_LENGTH  ALU result
- rf_write_reg  out  2  to register file write_reg
- rf_write_data  out  WORD_LENGTH  to register file write_data
- rf_write_reg_en  out  1  to register file write_reg_en
- rf_czn  in  3  CZN from register file, {N,Z,C}
- flags  out  3  last captured CZN
- done  out  1  one-cycle completion pulse
- txn_count  out  8  completed transactions, wraps

Behaviour:
- Reset: at any rising edge with rst=1, all registers clear.
  - State goes to IDLE.
  - rf_read_reg1/2, rf_write_reg, rf_write_data, op_a, op_b, flags and txn_count all become 0.
  - op_valid, rf_write_reg_en and done become 0; req_ready becomes 1.
  - Reset in any state abandons the transaction with no write; rst dominates all other inputs.
- States: IDLE, READ, EXEC, WRITE, DONE.
- IDLE: req_ready=1.
  - On req_valid=1 at an edge, latch rs1/rs2/rd/wb, drive rf_read_reg1/2 from the latched values, load wait counter with READ_WAIT-1, go to READ.
- READ: the counter decrements each cycle.
  - At the edge where counter==0: op_a<=rf_read_data1, op_b<=rf_read_data2, go to EXEC.
  - Operand capture therefore occurs READ_WAIT edges after the accept edge.
- EXEC: op_valid=1.
  - On res_valid=1 with wb=1: rf_write_data<=res_data, go to WRITE.
  - On res_valid=1 with wb=0: go to DONE; flags are unchanged.
- WRITE: rf_write_reg_en=1 for exactly one cycle, with rf_write_reg=latched rd and rf_write_data stable.
  - At the end-of-cycle edge, flags<=rf_czn (the register file computes CZN from write_data in the same cycle). Go to DONE.
- DONE: done=1 for one cycle; txn_count increments (255 -> 0) at the exiting edge; go to IDLE.
- Output decode:
  - op_valid, rf_write_reg_en, done and req_ready are decoded from state; glitch-free relative to clk.
  - rf_read_reg1/2 hold their values until the next accept.
  - op_a and op_b hold until the next capture.
- Ignored inputs:
  - req_valid outside IDLE is ignored; the request is not queued.
  - res_valid outside EXEC is ignored.
  - res_data is sampled only at the accepting edge.
- Back-to-back: a new request may be accepted in the IDLE cycle immediately after DONE. Minimum transaction length is READ_WAIT+3 cycles (wb=1) or READ_WAIT+2 (wb=0), with res_valid already high on EXEC entry.
- rs1==rs2 and rd==rs1 are legal. Reads complete before the write, so there is no hazard logic.

Test Plan:
- Reset: hold rst=1 for 2 cycles mid-traffic -> all outputs 0, state IDLE, req_ready=1 on the first cycle after release.
- Full writeback (READ_WAIT=1): rs1=1, rs2=2, rd=3, wb=1, rf_read_data1=0x12, rf_read_data2=0x34, res_valid with 0x46 one cycle after op_valid, rf_czn=3'b000 ->
  - rf_read_reg1=1, rf_read_reg2=2 after accept;
  - op_a=0x12, op_b=0x34, op_valid 1 edge later;
  - single-cycle rf_write_reg_en with rf_write_reg=3 and rf_write_data=0x46;
  - flags=3'b000, one-cycle done pulse, txn_count=1.
- Zero result: res_data=0x00 with rf_czn=3'b010 during WRITE -> flags=3'b010. A following wb=0 transaction never asserts rf_write_reg_en and flags stay 3'b010.
- Protocol noise: req_valid held high through the transaction and res_valid pulsed during READ -> only one transaction, res_valid in READ ignored, req_ready low from accept through DONE.
- Latency: READ_WAIT=3 -> op_a/op_b captured exactly 3 edges after accept. READ_WAIT=0 behaves identically to READ_WAIT=1.
- Reset mid-EXEC, then 256 back-to-back transactions ->
  - after the reset: no rf_write_reg_en pulse and op_valid=0;
  - after the 256 transactions: txn_count wraps to 0.

Source files
------------

// File: rtl/regfile_access_sequencer.sv
// regfile_access_sequencer: initiator for the 4xWORD_LENGTH accumulator register file.
//   Accepts one request at a time, reads two operands, hands them to the ALU, waits
//   for the result, optionally writes it back for one cycle and captures the CZN flags.
// Ports: req_* (controller request, req_ready high only when idle), rf_* (register
//   file pins), op_a/op_b/op_valid + res_valid/res_data (ALU handshake), flags, done,
//   txn_count (completed transactions, 8-bit wrapping).
module regfile_access_sequencer #(
  parameter int WORD_LENGTH = 8,
  parameter int READ_WAIT   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_rs1,
  input  logic [1:0]             req_rs2,
  input  logic [1:0]             req_rd,
  input  logic                   req_wb,
  output logic [1:0]             rf_read_reg1,
  output logic [1:0]             rf_read_reg2,
  input  logic [WORD_LENGTH-1:0] rf_read_data1,
  input  logic [WORD_LENGTH-1:0] rf_read_data2,
  output logic [WORD_LENGTH-1:0] op_a,
  output logic [WORD_LENGTH-1:0] op_b,
  output logic                   op_valid,
  input  logic                   res_valid,
  input  logic [WORD_LENGTH-1:0] res_data,
  output logic [1:0]             rf_write_reg,
  output logic [WORD_LENGTH-1:0] rf_write_data,
  output logic                   rf_write_reg_en,
  input  logic [2:0]             rf_czn,
  output logic [2:0]             flags,
  output logic                   done,
  output logic [7:0]             txn_count
);

  // A READ_WAIT of 0 would leave no cycle for the register file to respond.
  localparam int         RW_EFF    = (READ_WAIT < 1) ? 1 : READ_WAIT;
  localparam logic [7:0] WAIT_LOAD = 8'(RW_EFF - 1);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_WRITE, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [1:0]             rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic                   wb_q, wb_d;
  logic [WORD_LENGTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d, wdata_q, wdata_d;
  logic [2:0]             flags_q, flags_d;
  logic [7:0]             txn_q, txn_d;
  logic                   op_valid_q, op_valid_d, wen_q, wen_d;
  logic                   done_q, done_d, ready_q, ready_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    wb_d    = wb_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    wdata_d = wdata_q;
    flags_d = flags_q;
    txn_d   = txn_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          rs1_d   = req_rs1;
          rs2_d   = req_rs2;
          rd_d    = req_rd;
          wb_d    = req_wb;
          cnt_d   = WAIT_LOAD;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (cnt_q == 8'd0) begin
          op_a_d  = rf_read_data1;
          op_b_d  = rf_read_data2;
          state_d = S_EXEC;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_EXEC: begin
        if (res_valid) begin
          if (wb_q) begin
            wdata_d = res_data;
            state_d = S_WRITE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_WRITE: begin
        // The register file derives CZN from write_data during this cycle.
        flags_d = rf_czn;
        state_d = S_DONE;
      end
      S_DONE: begin
        txn_d   = txn_q + 8'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Strobes are registered from the next state so they change only on clk.
    op_valid_d = (state_d == S_EXEC);
    wen_d      = (state_d == S_WRITE);
    done_d     = (state_d == S_DONE);
    ready_d    = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      rs1_q      <= 2'd0;
      rs2_q      <= 2'd0;
      rd_q       <= 2'd0;
      wb_q       <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      wdata_q    <= '0;
      flags_q    <= 3'd0;
      txn_q      <= 8'd0;
      op_valid_q <= 1'b0;
      wen_q      <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      wb_q       <= wb_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      wdata_q    <= wdata_d;
      flags_q    <= flags_d;
      txn_q      <= txn_d;
      op_valid_q <= op_valid_d;
      wen_q      <= wen_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
    end
  end

  assign req_ready       = ready_q;
  assign rf_read_reg1    = rs1_q;
  assign rf_read_reg2    = rs2_q;
  assign op_a            = op_a_q;
  assign op_b            = op_b_q;
  assign op_valid        = op_valid_q;
  assign rf_write_reg    = rd_q;
  assign rf_write_data   = wdata_q;
  assign rf_write_reg_en = wen_q;
  assign flags           = flags_q;
  assign done            = done_q;
  assign txn_count       = txn_q;

endmodule
